// File: rtl/pc_npc_sequencer.sv
// PC/nPC sequencer with SPARC delayed-branch semantics, paired with branch_Aux.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned JMPL/branch targets trap
// to TRAP_VECTOR and pulse out_misalign instead of being loaded).
module pc_npc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        in_step,
  input  logic        in_branch,
  input  logic        in_call,
  input  logic        in_jmpl,
  input  logic        in_taken,
  input  logic        in_uncond,
  input  logic        in_a,
  input  logic [31:0] in_jmpl_target,
  input  logic [31:0] in_target,
  input  logic        in_trap,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  output logic        out_baux,
  output logic        out_disp_sel,
  output logic        out_busy,
  output logic        out_annul,
  output logic        out_misalign
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC    = XLEN'(4);
  localparam logic [XLEN-1:0] RESET_NPC = RESET_PC + PC_INC;
  localparam logic [XLEN-1:0] TRAP_NPC  = TRAP_VECTOR + PC_INC;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_STROBE  = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic            baux_q, baux_d;
  logic            disp_sel_q, disp_sel_d;
  logic            busy_q, busy_d;
  logic            annul_q, annul_d;
  logic            annul_pend_q, annul_pend_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] npc_inc_c;
  logic            jmpl_bad_c;
  logic            tgt_bad_c;

  assign npc_inc_c = npc_q + PC_INC;

  // Target alignment qualification
`ifdef PC_ALIGN_CHECK_EN
  assign jmpl_bad_c = |in_jmpl_target[1:0];
  assign tgt_bad_c  = |in_target[1:0];
`else
  assign jmpl_bad_c = 1'b0;
  assign tgt_bad_c  = 1'b0;
`endif

  // Next-state and next-output logic; trap wins over busy sequencing, which wins over step
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    baux_d       = 1'b0;
    disp_sel_d   = disp_sel_q;
    busy_d       = busy_q;
    annul_d      = annul_q;
    annul_pend_d = annul_pend_q;
    misalign_d   = 1'b0;

    if (in_trap) begin
      // Vector to trap handler; any in-flight target fetch is dropped
      state_d      = S_RUN;
      pc_d         = TRAP_VECTOR;
      npc_d        = TRAP_NPC;
      disp_sel_d   = 1'b0;
      busy_d       = 1'b0;
      annul_d      = 1'b0;
      annul_pend_d = 1'b0;
    end else begin
      case (state_q)
        S_STROBE: begin
          // PC held so branch_Aux computes from the branch's own PC
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          state_d      = S_RUN;
          busy_d       = 1'b0;
          disp_sel_d   = 1'b0;
          annul_pend_d = 1'b0;
          if (tgt_bad_c) begin
            pc_d       = TRAP_VECTOR;
            npc_d      = TRAP_NPC;
            annul_d    = 1'b0;
            misalign_d = 1'b1;
          end else begin
            // Move onto the delay slot; taken BA,a annuls it here
            pc_d    = npc_q;
            npc_d   = in_target;
            annul_d = annul_pend_q;
          end
        end
        default: begin
          if (in_step) begin
            if (annul_q) begin
              // Annulled delay slot: just advance, never branch
              pc_d    = npc_q;
              npc_d   = npc_inc_c;
              annul_d = 1'b0;
            end else if (in_call || (in_branch && in_taken)) begin
              state_d      = S_STROBE;
              baux_d       = 1'b1;
              busy_d       = 1'b1;
              disp_sel_d   = in_call;
              annul_pend_d = !in_call && in_branch && in_a && in_uncond;
              annul_d      = 1'b0;
            end else if (in_jmpl) begin
              annul_d = 1'b0;
              if (jmpl_bad_c) begin
                pc_d       = TRAP_VECTOR;
                npc_d      = TRAP_NPC;
                misalign_d = 1'b1;
              end else begin
                pc_d  = npc_q;
                npc_d = in_jmpl_target;
              end
            end else begin
              // Plain instruction or untaken Bicc (annul delay slot if a=1)
              pc_d    = npc_q;
              npc_d   = npc_inc_c;
              annul_d = in_branch && in_a;
            end
          end
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      npc_q        <= RESET_NPC;
      baux_q       <= 1'b0;
      disp_sel_q   <= 1'b0;
      busy_q       <= 1'b0;
      annul_q      <= 1'b0;
      annul_pend_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      baux_q       <= baux_d;
      disp_sel_q   <= disp_sel_d;
      busy_q       <= busy_d;
      annul_q      <= annul_d;
      annul_pend_q <= annul_pend_d;
      misalign_q   <= misalign_d;
    end
  end

  assign out_pc       = pc_q;
  assign out_npc      = npc_q;
  assign out_baux     = baux_q;
  assign out_disp_sel = disp_sel_q;
  assign out_busy     = busy_q;
  assign out_annul    = annul_q;
  assign out_misalign = misalign_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Self-checking bench for pc_npc_sequencer: expected snapshots queued with stimulus,
// observed snapshots queued one step after each clock edge, compared per scenario.
module tb_pc_npc_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        baux;
    logic        ds;
    logic        busy;
    logic        annul;
    logic        mis;
  } snap_t;

  logic        Clk;
  logic        Reset_n;
  logic        in_step, in_branch, in_call, in_jmpl, in_taken, in_uncond, in_a, in_trap;
  logic [31:0] in_jmpl_target, in_target;
  logic [31:0] out_pc, out_npc;
  logic        out_baux, out_disp_sel, out_busy, out_annul, out_misalign;

  snap_t exp_q[$];
  snap_t obs_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  pc_npc_sequencer dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .in_step        (in_step),
    .in_branch      (in_branch),
    .in_call        (in_call),
    .in_jmpl        (in_jmpl),
    .in_taken       (in_taken),
    .in_uncond      (in_uncond),
    .in_a           (in_a),
    .in_jmpl_target (in_jmpl_target),
    .in_target      (in_target),
    .in_trap        (in_trap),
    .out_pc         (out_pc),
    .out_npc        (out_npc),
    .out_baux       (out_baux),
    .out_disp_sel   (out_disp_sel),
    .out_busy       (out_busy),
    .out_annul      (out_annul),
    .out_misalign   (out_misalign)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic snap_t cur();
    snap_t s;
    s.pc    = out_pc;
    s.npc   = out_npc;
    s.baux  = out_baux;
    s.ds    = out_disp_sel;
    s.busy  = out_busy;
    s.annul = out_annul;
    s.mis   = out_misalign;
    return s;
  endfunction

  task automatic expect_snap(input string n, input logic [31:0] pc, input logic [31:0] npc,
                             input logic baux, input logic ds, input logic busy,
                             input logic annul, input logic mis);
    snap_t s;
    s = '{pc: pc, npc: npc, baux: baux, ds: ds, busy: busy, annul: annul, mis: mis};
    exp_q.push_back(s);
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    obs_q.push_back(cur());
  endtask

  task automatic idle();
    in_step = 0; in_branch = 0; in_call = 0; in_jmpl = 0; in_taken = 0;
    in_uncond = 0; in_a = 0; in_trap = 0;
  endtask

  task automatic test_reset();
    snap_t o, e; string n;
    idle();
    in_jmpl_target = 32'h0; in_target = 32'h0;
    Reset_n = 0;
    repeat (2) @(posedge Clk);
    #1;
    expect_snap("reset", 32'h0, 32'h4, 0, 0, 0, 0, 0);
    obs_q.push_back(cur());
    Reset_n = 1;
    in_step = 1;
    expect_snap("plain1", 32'h4, 32'h8, 0, 0, 0, 0, 0); tick();
    expect_snap("plain2", 32'h8, 32'hC, 0, 0, 0, 0, 0); tick();
    expect_snap("plain3", 32'hC, 32'h10, 0, 0, 0, 0, 0); tick();
    idle();
    expect_snap("hold", 32'hC, 32'h10, 0, 0, 0, 0, 0); tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got {pc,npc,baux,ds,busy,annul,mis}=%h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_taken_ba();
    snap_t o, e; string n;
    in_step = 1; in_jmpl = 1; in_jmpl_target = 32'h100;
    expect_snap("ba_jmpl", 32'h10, 32'h100, 0, 0, 0, 0, 0); tick();
    in_jmpl = 0;
    expect_snap("ba_setup", 32'h100, 32'h104, 0, 0, 0, 0, 0); tick();
    in_branch = 1; in_taken = 1; in_uncond = 1; in_a = 0; in_target = 32'h200;
    expect_snap("ba_strobe", 32'h100, 32'h104, 1, 0, 1, 0, 0); tick();
    // step kept high during busy must be ignored
    in_branch = 0; in_taken = 0; in_uncond = 0;
    expect_snap("ba_capture", 32'h100, 32'h104, 0, 0, 1, 0, 0); tick();
    expect_snap("ba_exit", 32'h104, 32'h200, 0, 0, 0, 0, 0); tick();
    expect_snap("ba_next", 32'h200, 32'h204, 0, 0, 0, 0, 0); tick();
    idle();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got {pc,npc,baux,ds,busy,annul,mis}=%h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_annul();
    snap_t o, e; string n;
    in_step = 1; in_jmpl = 1; in_jmpl_target = 32'h100;
    expect_snap("an_jmpl", 32'h204, 32'h100, 0, 0, 0, 0, 0); tick();
    in_jmpl = 0;
    expect_snap("an_setup", 32'h100, 32'h104, 0, 0, 0, 0, 0); tick();
    in_branch = 1; in_taken = 0; in_a = 1;
    expect_snap("an_nt_a1", 32'h104, 32'h108, 0, 0, 0, 1, 0); tick();
    // annulled slot: decode claims a taken branch, must not branch
    in_taken = 1; in_a = 0;
    expect_snap("an_slot", 32'h108, 32'h10C, 0, 0, 0, 0, 0); tick();
    // taken BA with a=1 annuls delay slot at capture exit
    in_uncond = 1; in_a = 1; in_target = 32'h300;
    expect_snap("ba_a1_strobe", 32'h108, 32'h10C, 1, 0, 1, 0, 0); tick();
    idle();
    expect_snap("ba_a1_capture", 32'h108, 32'h10C, 0, 0, 1, 0, 0); tick();
    expect_snap("ba_a1_exit", 32'h10C, 32'h300, 0, 0, 0, 1, 0); tick();
    in_step = 1; in_jmpl = 1; in_jmpl_target = 32'h500;
    expect_snap("ba_a1_slot", 32'h300, 32'h304, 0, 0, 0, 0, 0); tick();
    // taken conditional with a=1 does not annul
    in_jmpl = 0; in_branch = 1; in_taken = 1; in_uncond = 0; in_a = 1; in_target = 32'h400;
    expect_snap("bc_a1_strobe", 32'h300, 32'h304, 1, 0, 1, 0, 0); tick();
    idle();
    expect_snap("bc_a1_capture", 32'h300, 32'h304, 0, 0, 1, 0, 0); tick();
    expect_snap("bc_a1_exit", 32'h304, 32'h400, 0, 0, 0, 0, 0); tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got {pc,npc,baux,ds,busy,annul,mis}=%h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_call_jmpl();
    snap_t o, e; string n;
    in_step = 1; in_jmpl = 1; in_jmpl_target = 32'h40;
    expect_snap("call_jmpl", 32'h400, 32'h40, 0, 0, 0, 0, 0); tick();
    in_jmpl = 0;
    expect_snap("call_setup", 32'h40, 32'h44, 0, 0, 0, 0, 0); tick();
    in_call = 1; in_target = 32'h1000;
    expect_snap("call_strobe", 32'h40, 32'h44, 1, 1, 1, 0, 0); tick();
    idle();
    expect_snap("call_capture", 32'h40, 32'h44, 0, 1, 1, 0, 0); tick();
    expect_snap("call_exit", 32'h44, 32'h1000, 0, 0, 0, 0, 0); tick();
    in_step = 1; in_jmpl = 1; in_jmpl_target = 32'h2000;
    expect_snap("jmpl", 32'h1000, 32'h2000, 0, 0, 0, 0, 0); tick();
    idle();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got {pc,npc,baux,ds,busy,annul,mis}=%h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_trap_reset();
    snap_t o, e; string n;
    in_step = 1; in_branch = 1; in_taken = 1; in_target = 32'h3000;
    expect_snap("trap_strobe", 32'h1000, 32'h2000, 1, 0, 1, 0, 0); tick();
    idle(); in_trap = 1;
    expect_snap("trap_taken", 32'h80, 32'h84, 0, 0, 0, 0, 0); tick();
    in_trap = 0;
    expect_snap("trap_hold", 32'h80, 32'h84, 0, 0, 0, 0, 0); tick();
    in_step = 1; in_branch = 1; in_taken = 1;
    expect_snap("rst_strobe", 32'h80, 32'h84, 1, 0, 1, 0, 0); tick();
    idle();
    expect_snap("rst_capture", 32'h80, 32'h84, 0, 0, 1, 0, 0); tick();
    #2 Reset_n = 0;
    #1;
    expect_snap("async_reset", 32'h0, 32'h4, 0, 0, 0, 0, 0);
    obs_q.push_back(cur());
    @(posedge Clk);
    #1 Reset_n = 1;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got {pc,npc,baux,ds,busy,annul,mis}=%h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_wrap_align();
    snap_t o, e; string n;
    in_step = 1; in_jmpl = 1; in_jmpl_target = 32'hFFFF_FFF8;
    expect_snap("wrap_jmpl", 32'h4, 32'hFFFF_FFF8, 0, 0, 0, 0, 0); tick();
    in_jmpl = 0;
    expect_snap("wrap1", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0, 0, 0, 0); tick();
    expect_snap("wrap2", 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0); tick();
    in_jmpl = 1; in_jmpl_target = 32'h202;
`ifdef PC_ALIGN_CHECK_EN
    expect_snap("misalign", 32'h80, 32'h84, 0, 0, 0, 0, 1); tick();
    idle();
    expect_snap("misalign_clr", 32'h80, 32'h84, 0, 0, 0, 0, 0); tick();
`else
    expect_snap("unaligned_load", 32'h0, 32'h202, 0, 0, 0, 0, 0); tick();
    idle();
    expect_snap("unaligned_hold", 32'h0, 32'h202, 0, 0, 0, 0, 0); tick();
`endif
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got {pc,npc,baux,ds,busy,annul,mis}=%h want %h", n, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_taken_ba();
    test_annul();
    test_call_jmpl();
    test_trap_reset();
    test_wrap_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_npc_sequencer.md
Name: pc_npc_sequencer

Overview:
- Holds the architectural PC/nPC pair and advances it with SPARC delayed-branch semantics.
- Directly upstream and downstream of branch_Aux:
  - drives branch_Aux in_pc with out_pc;
  - issues the BAUX strobe and dispSel;
  - captures the branch_Aux out target into nPC.
- Also handles delay-slot annulment, JMPL targets and trap vectoring.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset (nPC = RESET_PC+4).
- TRAP_VECTOR, 32'h0000_0080, PC loaded on trap (nPC = TRAP_VECTOR+4).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- in_step  input  1  decode retires current instruction this cycle; ignored while out_busy=1.
- in_branch  input  1  current instruction is Bicc (disp22); qualified by in_step.
- in_call  input  1  current instruction is CALL (disp30); always taken.
- in_jmpl  input  1  current instruction is JMPL.
- in_taken  input  1  Bicc condition true.
- in_uncond  input  1  Bicc is BA (cond=1000).
- in_a  input  1  Bicc annul bit.
- in_jmpl_target  input  32  JMPL target address.
- in_target  input  32  branch_Aux out.
- in_trap  input  1  trap request, level-sampled.
- out_pc  output  32  current PC; also feeds branch_Aux in_pc.
- out_npc  output  32  next PC.
- out_baux  output  1  BAUX strobe to branch_Aux.
- out_disp_sel  output  1  dispSel to branch_Aux: 1=disp30 (CALL), 0=disp22.
- out_busy  output  1  target fetch in progress; decode must hold.
- out_annul  output  1  instruction at out_pc is annulled.
- out_misalign  output  1  misaligned target trap pulse (see Optional Feature).

Behaviour:
- Reset (Reset_n=0, async, any state):
  - out_pc=RESET_PC, out_npc=RESET_PC+4, state=S_RUN.
  - out_baux, out_disp_sel, out_busy, out_annul, out_misalign all 0.
- All outputs are registered.
- All PC arithmetic is modulo 2^32: nPC 32'hFFFF_FFFC +4 gives 0.
- Priority per edge: in_trap > busy-state sequencing > in_step.
- Trap, in any state:
  - PC<=TRAP_VECTOR, nPC<=TRAP_VECTOR+4, annul<=0, state<=S_RUN.
  - An in-flight target fetch is discarded.
- S_RUN, in_step=0: hold all state.
- S_RUN, in_step=1, by instruction type:
  - Plain instruction, or Bicc not taken: PC<=nPC, nPC<=nPC+4.
  - JMPL: PC<=nPC, nPC<=in_jmpl_target.
  - Taken Bicc, or CALL: no PC change; state<=S_STROBE; out_disp_sel<=in_call; out_busy<=1.
- S_STROBE, one cycle:
  - out_baux=1, out_busy=1; PC held, so branch_Aux sees the branch's PC.
  - state<=S_CAPTURE.
- S_CAPTURE, one cycle:
  - out_baux=0, out_busy=1.
  - At the closing edge: PC<=nPC, nPC<=in_target, out_busy<=0, state<=S_RUN.
- out_disp_sel is stable from entry to S_STROBE until leaving S_CAPTURE.
- Taken-branch/CALL penalty is exactly 2 cycles of out_busy.
- Annulment, decided in S_RUN at the step of a Bicc with in_a=1:
  - Annul if the branch is not taken, or if taken and in_uncond=1.
  - The annul flag is registered alongside the PC update that moves onto the delay slot. For taken BA that update is the S_CAPTURE exit.
  - out_annul=1 while out_pc is the delay slot; cleared on the next step.
  - An annulled delay-slot step never branches, even if decode reports in_branch/in_jmpl.
- Taken conditional Bicc with a=1: delay slot not annulled.
- in_step asserted during out_busy: ignored, no state change.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: a JMPL target, or a captured in_target, with bits[1:0]!=0 is not loaded. Instead:
  - PC<=TRAP_VECTOR, nPC<=TRAP_VECTOR+4;
  - out_misalign=1 for exactly one cycle;
  - annul cleared.
- Undefined: targets loaded unmodified; out_misalign tied 0.

Test Plan:
- Reset with RESET_PC=0 -> pc=0, npc=4, busy=0, annul=0. Three plain steps -> pc=C, npc=10.
- pc=100, npc=104, taken BA a=0, branch_Aux returns 200 -> baux pulses 1 cycle, busy=2 cycles. Then pc=104, npc=200, annul=0. Next step -> pc=200.
- pc=100, not-taken Bicc a=1 -> pc=104 with annul=1, npc=108. Next step -> annul=0, pc=108.
- pc=40, CALL, in_target=1000 -> disp_sel=1 across strobe/capture, npc=1000. JMPL with target 2000 -> npc=2000 without busy.
- in_trap during S_STROBE -> pc=80, npc=84, busy=0, baux=0 next cycle. Reset_n pulled low mid S_CAPTURE -> immediate pc=0, npc=4.
- PC_ALIGN_CHECK_EN defined, JMPL target 202 -> misalign pulse, pc=80, npc=84. With the macro undefined -> npc=202.
